// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: raster grayscale pixels in, one edge-map write per pixel out.
// Two line buffers feed a 3x3 window; a FLUSH phase pads WIDTH+1 beats so the last rows drain.
module sobel_edge_stream #(
    parameter int WIDTH  = 640,
    parameter int DEPTH  = 480,
    parameter int PIX_W  = 8,
    parameter int THRESH = 128,
    parameter int ADDR_W = $clog2(WIDTH*DEPTH)
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              edge_we,
    output logic [ADDR_W-1:0] edge_addr,
    output logic              edge_bit,
    output logic              frame_done
);
    localparam int N  = WIDTH*DEPTH;
    localparam int BW = $clog2(N+WIDTH+1);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW = PIX_W + 3;

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_nx;

    logic [BW-1:0]               beat;   // beats this frame, flush beats included
    logic [CW-1:0]               col;    // column of the incoming beat
    logic [RW-1:0]               crow;   // centre of the next emitted result
    logic [CW-1:0]               ccol;
    logic                        fire, emit, last_beat;
    logic [PIX_W-1:0]            pix;
    logic [WIDTH-1:0][PIX_W-1:0] lb_a, lb_b;
    logic [2:0][2:0][PIX_W-1:0]  win;
    logic [1:0]                  vld_pipe;
    logic                        s1_border, s1_last;
    logic [ADDR_W-1:0]           s1_addr;
    logic signed [MW-1:0]        gx, gy;
    logic [MW-1:0]               mag;

    assign last_beat = (beat == BW'(N+WIDTH));
    assign emit      = fire && (beat >= BW'(WIDTH+1));
    assign edge_we   = vld_pipe[1];

    always_comb begin
        state_nx  = state;
        pix_ready = 1'b0;
        fire      = 1'b0;
        pix       = '0;
        case (state)
            RUN: begin
                pix_ready = 1'b1;
                fire      = pix_valid;
                pix       = pix_in;
                if (pix_valid && beat == BW'(N-1)) state_nx = FLUSH;
            end
            FLUSH: begin
                fire = 1'b1;
                if (last_beat) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            state <= RUN;
            beat  <= '0;
            col   <= '0;
            crow  <= '0;
            ccol  <= '0;
        end else begin
            state <= state_nx;
            if (fire) begin
                beat <= last_beat ? '0 : beat + BW'(1);
                col  <= (last_beat || col == CW'(WIDTH-1)) ? '0 : col + CW'(1);
            end
            if (emit) begin
                ccol <= (ccol == CW'(WIDTH-1)) ? '0 : ccol + CW'(1);
                if (ccol == CW'(WIDTH-1))
                    crow <= (crow == RW'(DEPTH-1)) ? '0 : crow + RW'(1);
            end
        end
    end

    // Line buffers and window hold data only; stale contents only ever reach border centres.
    always_ff @(posedge dclk) begin
        if (fire) begin
            lb_b[col] <= lb_a[col];
            lb_a[col] <= pix;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb_b[col];
            win[1][2] <= lb_a[col];
            win[2][2] <= pix;
        end
    end

    function automatic logic signed [MW-1:0] sx(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // win[row][col]: row 0 is top, col 2 is the newest column
    always_comb begin
        gx  = (sx(win[0][2]) + (sx(win[1][2]) <<< 1) + sx(win[2][2]))
            - (sx(win[0][0]) + (sx(win[1][0]) <<< 1) + sx(win[2][0]));
        gy  = (sx(win[2][0]) + (sx(win[2][1]) <<< 1) + sx(win[2][2]))
            - (sx(win[0][0]) + (sx(win[0][1]) <<< 1) + sx(win[0][2]));
        mag = $unsigned(gx[MW-1] ? -gx : gx) + $unsigned(gy[MW-1] ? -gy : gy);
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            vld_pipe   <= '0;
            s1_addr    <= '0;
            s1_border  <= 1'b0;
            s1_last    <= 1'b0;
            edge_addr  <= '0;
            edge_bit   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vld_pipe[0] <= emit;
            if (emit) begin
                s1_addr   <= ADDR_W'(beat - BW'(WIDTH+1));
                s1_border <= (crow == '0) || (crow == RW'(DEPTH-1)) ||
                             (ccol == '0) || (ccol == CW'(WIDTH-1));
                s1_last   <= last_beat;
            end
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) edge_addr <= s1_addr;
            edge_bit   <= vld_pipe[0] && !s1_border && (mag >= MW'(THRESH));
            frame_done <= vld_pipe[0] && s1_last;
        end
    end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Bench for sobel_edge_stream on an 8x6 frame: table of frame patterns checked against a 2-D Sobel model.
module tb_sobel_edge_stream;
    localparam int W   = 8;
    localparam int D   = 6;
    localparam int N   = W*D;
    localparam int TH  = 128;
    localparam int AW  = $clog2(N);
    localparam int LAT = W + 1;

    logic          dclk = 1'b0;
    logic          clr = 1'b1;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_in = '0;
    logic          pix_ready, edge_we, edge_bit, frame_done;
    logic [AW-1:0] edge_addr;

    sobel_edge_stream #(.WIDTH(W), .DEPTH(D), .PIX_W(8), .THRESH(TH), .ADDR_W(AW)) dut (
        .dclk(dclk), .clr(clr), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .edge_we(edge_we), .edge_addr(edge_addr), .edge_bit(edge_bit), .frame_done(frame_done)
    );

    always #5 dclk = ~dclk;

    typedef struct { int addr; int b; int fd; int cyc; } wr_t;
    typedef struct { string name; int pat; int gap; int exp_ones; } vec_t;

    wr_t wq[$];
    int  acc[$];
    wr_t mon_w;
    int  cyc = 0, lowcnt = 0, stray = 0;
    int  tests = 0, fails = 0;
    int  img[D][W];

    always @(posedge dclk) cyc <= cyc + 1;

    always @(negedge dclk) begin
        if (edge_we) begin
            mon_w = '{int'(edge_addr), int'(edge_bit), int'(frame_done), cyc};
            wq.push_back(mon_w);
        end
        if (frame_done && !edge_we) stray++;
        if (pix_valid && pix_ready && !clr) acc.push_back(cyc);
        if (!pix_ready) lowcnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_bit(input int k);
        int r = k / W;
        int c = k % W;
        int gx = 0;
        int gy = 0;
        int mag;
        if (r == 0 || r == D-1 || c == 0 || c == W-1) return 0;
        for (int d = -1; d <= 1; d++) begin
            int wt = (d == 0) ? 2 : 1;
            gx += wt * (img[r+d][c+1] - img[r+d][c-1]);
            gy += wt * (img[r+1][c+d] - img[r-1][c+d]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag >= TH) ? 1 : 0;
    endfunction

    task automatic fill(input int pat);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c >= 4) ? 255 : 0;
                    2: img[r][c] = (r == 2 && c == 3) ? 64 : 0;
                    3: img[r][c] = (r == 2 && c == 3) ? 63 : 0;
                    4: img[r][c] = int'($urandom_range(255));
                    default: img[r][c] = int'($urandom_range(60));
                endcase
    endtask

    task automatic drive_frame(input int gap, input int count);
        int idx = 0;
        int guard = 0;
        while (idx < count && guard < 4000) begin
            @(posedge dclk); #1;
            pix_valid = ($urandom_range(99) >= gap);
            pix_in    = 8'(img[idx / W][idx % W]);
            if (pix_valid && pix_ready) idx++;
            guard++;
        end
        if (guard >= 4000) chk("drive_timeout", idx, count);
        @(posedge dclk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input int wb, input int ab, input int exp_ones);
        int ones = 0;
        if (wq.size() - wb < N || acc.size() - ab < N) begin
            chk({name, "_short"}, wq.size() - wb, N);
            return;
        end
        for (int j = 0; j < N; j++) begin
            wr_t w;
            int  i;
            int  exp_cyc;
            w = wq[wb+j];
            i = j + LAT;
            exp_cyc = (i < N) ? acc[ab+i] + 2 : acc[ab+N-1] + 2 + (i - (N-1));
            chk({name, "_addr"}, w.addr, j);
            chk({name, "_bit"}, w.b, ref_bit(j));
            chk({name, "_frame_done"}, w.fd, (j == N-1) ? 1 : 0);
            chk({name, "_latency"}, w.cyc, exp_cyc);
            ones += w.b;
        end
        if (exp_ones >= 0) chk({name, "_ones"}, ones, exp_ones);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   wb, ab, lb;
        vecs[0] = '{"uniform",    0, 0,  0};
        vecs[1] = '{"vstep",      1, 0,  8};
        vecs[2] = '{"vstep_gaps", 1, 50, 8};
        vecs[3] = '{"dot64",      2, 0,  8};
        vecs[4] = '{"dot63",      3, 0,  0};
        vecs[5] = '{"rand",       4, 0,  -1};
        vecs[6] = '{"rand_gaps",  5, 40, -1};

        repeat (3) @(posedge dclk);
        #1;
        chk("rst_pix_ready", int'(pix_ready), 1);
        chk("rst_edge_we", int'(edge_we), 0);
        chk("rst_edge_addr", int'(edge_addr), 0);
        chk("rst_edge_bit", int'(edge_bit), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        clr = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].pat);
            wb = wq.size(); ab = acc.size(); lb = lowcnt;
            drive_frame(vecs[v].gap, N);
            repeat (LAT + 6) @(posedge dclk);
            #1;
            chk({vecs[v].name, "_nwrites"}, wq.size() - wb, N);
            chk({vecs[v].name, "_ready_low"}, lowcnt - lb, LAT);
            check_frame(vecs[v].name, wb, ab, vecs[v].exp_ones);
        end

        // clr after 20 accepts: in-flight writes dropped, next pixel restarts at (0,0)
        fill(0);
        drive_frame(0, 20);
        clr = 1'b1;
        @(posedge dclk); #1;
        chk("clr_edge_we", int'(edge_we), 0);
        chk("clr_pix_ready", int'(pix_ready), 1);
        chk("clr_edge_addr", int'(edge_addr), 0);
        chk("clr_frame_done", int'(frame_done), 0);
        clr = 1'b0;
        wb = wq.size();
        repeat (4) @(posedge dclk);
        #1;
        chk("clr_dropped", wq.size() - wb, 0);
        wb = wq.size(); ab = acc.size(); lb = lowcnt;
        drive_frame(0, N);
        repeat (LAT + 6) @(posedge dclk);
        #1;
        chk("after_clr_nwrites", wq.size() - wb, N);
        chk("after_clr_ready_low", lowcnt - lb, LAT);
        check_frame("after_clr", wb, ab, 0);

        // two frames back to back
        fill(1);
        wb = wq.size(); ab = acc.size(); lb = lowcnt;
        drive_frame(0, N);
        drive_frame(0, N);
        repeat (LAT + 6) @(posedge dclk);
        #1;
        chk("b2b_nwrites", wq.size() - wb, 2*N);
        chk("b2b_ready_low", lowcnt - lb, 2*LAT);
        if (acc.size() - ab >= N + 1)
            chk("b2b_restart_gap", acc[ab+N] - acc[ab+N-1], LAT + 1);
        else
            chk("b2b_accepts", acc.size() - ab, 2*N);
        check_frame("b2b_f0", wb, ab, 8);
        check_frame("b2b_f1", wb + N, ab + N, 8);
        chk("stray_frame_done", stray, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
